// File: rtl/fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue
//
// IF/ID boundary buffer. Fetched {instr, PC, PC+4} triples enter a DEPTH-entry
// FIFO, and the head of the FIFO feeds the decode-stage register. The block
// also provides stall, flush, bubble insertion, and a zero-latency bypass
// from fetch straight into decode when the FIFO is empty.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   push_valid_i    fetch presents an instruction this cycle
//   push_ready_o    FIFO not full (depends only on count, never on stall)
//   InstrF_i        fetched instruction
//   PCF_i           PC of the fetched instruction
//   PCPlus4F_i      PC+4 of the fetched instruction
//   StallD_i        hold the decode register
//   FlushD_i        discard the FIFO and the decode register (wins over stall)
//   InstrD_o        decode instruction (NOP_INSTR when this is a bubble)
//   PCD_o           decode PC (0 when this is a bubble)
//   PCPlus4D_o      decode PC+4 (0 when this is a bubble)
//   ValidD_o        decode register holds a real instruction
//   count_o         FIFO occupancy, not counting the decode register
// -----------------------------------------------------------------------------
module fetch_decode_queue #(
   parameter int unsigned          DATA_WIDTH = 32,
   parameter int unsigned          DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_valid_i,
   output logic                         push_ready_o,
   input  logic [DATA_WIDTH-1:0]        InstrF_i,
   input  logic [DATA_WIDTH-1:0]        PCF_i,
   input  logic [DATA_WIDTH-1:0]        PCPlus4F_i,
   input  logic                         StallD_i,
   input  logic                         FlushD_i,
   output logic [DATA_WIDTH-1:0]        InstrD_o,
   output logic [DATA_WIDTH-1:0]        PCD_o,
   output logic [DATA_WIDTH-1:0]        PCPlus4D_o,
   output logic                         ValidD_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] instr;
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] pc_plus4;
   } entry_t;

   localparam entry_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};

   entry_t            mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   entry_t            dec_q, dec_d;
   logic              valid_q, valid_d;

   entry_t push_entry;
   logic   fifo_empty;
   logic   push_acc;
   logic   advance;
   logic   pop;
   logic   bypass;
   logic   wr_en;

   assign push_entry = '{instr: InstrF_i, pc: PCF_i, pc_plus4: PCPlus4F_i};

   // Ready is based on the registered count alone. A pop in the same cycle
   // does not raise it, so there is no combinational path from StallD_i.
   assign push_ready_o = (count_q != FULL_CNT);
   assign fifo_empty   = (count_q == '0);
   assign push_acc     = push_valid_i & push_ready_o & ~FlushD_i;
   assign advance      = ~StallD_i & ~FlushD_i;
   assign pop          = advance & ~fifo_empty;
   // When the FIFO is empty and decode is advancing, the push goes straight
   // into decode and never occupies a FIFO slot.
   assign bypass       = advance & fifo_empty & push_acc;
   assign wr_en        = push_acc & ~bypass;

   always_comb begin
      // NOTE: every variable this block drives gets a hold value first, so
      // no path through the if/case tree leaves one unassigned (no latches).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dec_d    = dec_q;
      valid_d  = valid_q;

      if (FlushD_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         dec_d    = BUBBLE;
         valid_d  = 1'b0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap naturally.
         if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);

         unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase

         if (advance) begin
            if (pop) begin
               dec_d   = mem_q[rd_ptr_q];
               valid_d = 1'b1;
            end else if (bypass) begin
               dec_d   = push_entry;
               valid_d = 1'b1;
            end else begin
               dec_d   = BUBBLE;
               valid_d = 1'b0;
            end
         end
      end
   end

   // NOTE: the storage array is deliberately not reset. The pointers and the
   // count decide which entries are live, so stale contents are never
   // observed, and leaving the array out of reset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_entry;
   end

   // NOTE: state registers use non-blocking assignments only. Every flop then
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dec_q    <= BUBBLE;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dec_q    <= dec_d;
         valid_q  <= valid_d;
      end
   end

   assign InstrD_o   = dec_q.instr;
   assign PCD_o      = dec_q.pc;
   assign PCPlus4D_o = dec_q.pc_plus4;
   assign ValidD_o   = valid_q;
   assign count_o    = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_queue
//
// Directed bench for fetch_decode_queue with DEPTH=4. The bench drives inputs
// 1 ns after each rising edge and checks outputs at that same point.
// -----------------------------------------------------------------------------
module tb_fetch_decode_queue;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        rst_n;
   logic        push_valid_i;
   logic        push_ready_o;
   logic [31:0] InstrF_i;
   logic [31:0] PCF_i;
   logic [31:0] PCPlus4F_i;
   logic        StallD_i;
   logic        FlushD_i;
   logic [31:0] InstrD_o;
   logic [31:0] PCD_o;
   logic [31:0] PCPlus4D_o;
   logic        ValidD_o;
   logic [2:0]  count_o;

   int n_checks = 0;
   int n_errors = 0;

   fetch_decode_queue #(
      .DATA_WIDTH (32),
      .DEPTH      (4),
      .NOP_INSTR  (NOP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_valid_i (push_valid_i),
      .push_ready_o (push_ready_o),
      .InstrF_i     (InstrF_i),
      .PCF_i        (PCF_i),
      .PCPlus4F_i   (PCPlus4F_i),
      .StallD_i     (StallD_i),
      .FlushD_i     (FlushD_i),
      .InstrD_o     (InstrD_o),
      .PCD_o        (PCD_o),
      .PCPlus4D_o   (PCPlus4D_o),
      .ValidD_o     (ValidD_o),
      .count_o      (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk_instr(input logic [31:0] pc);
      return pc ^ 32'hABCD_0000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_push(input logic v, input logic [31:0] pc);
      push_valid_i = v;
      PCF_i        = pc;
      PCPlus4F_i   = pc + 32'd4;
      InstrF_i     = mk_instr(pc);
   endtask

   task automatic check_bubble(input string tag);
      check({tag, "_valid"}, 32'(ValidD_o), 32'd0);
      check({tag, "_instr"}, InstrD_o, NOP);
      check({tag, "_pc"},    PCD_o, 32'd0);
      check({tag, "_pc4"},   PCPlus4D_o, 32'd0);
   endtask

   initial begin
      int m_cnt;
      int n_push;
      int n_pop;
      logic acc;

      rst_n    = 1'b0;
      StallD_i = 1'b0;
      FlushD_i = 1'b0;
      drive_push(1'b0, 32'd0);

      // Reset state
      #12;
      check_bubble("rst");
      check("rst_count", 32'(count_o), 32'd0);
      check("rst_ready", 32'(push_ready_o), 32'd1);
      rst_n = 1'b1;
      tick();

      // 1: bypass into decode with one edge of latency
      push_valid_i = 1'b1;
      InstrF_i     = 32'h00500093;
      PCF_i        = 32'd0;
      PCPlus4F_i   = 32'd4;
      tick();
      check("byp_instr", InstrD_o, 32'h00500093);
      check("byp_pc",    PCD_o, 32'd0);
      check("byp_pc4",   PCPlus4D_o, 32'd4);
      check("byp_valid", 32'(ValidD_o), 32'd1);
      check("byp_count", 32'(count_o), 32'd0);

      // 2: fill under stall, reject the fifth push, then drain in order
      StallD_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive_push(1'b1, 32'h10 + 32'(4 * k));
         tick();
      end
      check("fill_count", 32'(count_o), 32'd4);
      check("fill_ready", 32'(push_ready_o), 32'd0);
      check("fill_hold_pc", PCD_o, 32'd0);
      drive_push(1'b1, 32'h20);
      tick();
      check("fill_5th_count", 32'(count_o), 32'd4);
      drive_push(1'b0, 32'd0);
      StallD_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("drain_pc",    PCD_o, 32'h10 + 32'(4 * k));
         check("drain_instr", InstrD_o, mk_instr(32'h10 + 32'(4 * k)));
         check("drain_valid", 32'(ValidD_o), 32'd1);
         check("drain_count", 32'(count_o), 32'(3 - k));
      end
      tick();
      check_bubble("drain_end");

      // 3: flush overrides stall and drops the same-cycle push
      StallD_i = 1'b1;
      drive_push(1'b1, 32'h40);
      tick();
      drive_push(1'b1, 32'h44);
      tick();
      check("fl_pre_count", 32'(count_o), 32'd2);
      drive_push(1'b1, 32'h48);
      FlushD_i = 1'b1;
      tick();
      check("fl_count", 32'(count_o), 32'd0);
      check("fl_valid", 32'(ValidD_o), 32'd0);
      FlushD_i = 1'b0;
      StallD_i = 1'b0;
      drive_push(1'b0, 32'd0);
      tick();
      check_bubble("fl_after");
      check("fl_after_count", 32'(count_o), 32'd0);

      // 4: 12 pushes through the pointer wrap with stall toggling every 2 cycles
      m_cnt  = 0;
      n_push = 0;
      n_pop  = 0;
      for (int c = 0; c < 200 && n_pop < 12; c++) begin
         StallD_i = ((c / 2) % 2) == 1;
         drive_push(n_push < 12, 32'h100 + 32'(4 * n_push));
         check("wrap_ready", 32'(push_ready_o), 32'(m_cnt < 4));
         acc = push_valid_i && (m_cnt < 4);
         tick();
         if (StallD_i) begin
            if (acc) m_cnt++;
         end else begin
            check("wrap_valid", 32'(ValidD_o), 32'((m_cnt > 0) || acc));
            if (m_cnt > 0) m_cnt = m_cnt - 1 + int'(acc);
            if (ValidD_o) begin
               check("wrap_pc", PCD_o, 32'h100 + 32'(4 * n_pop));
               n_pop++;
            end
         end
         check("wrap_count", 32'(count_o), 32'(m_cnt));
         if (acc) n_push++;
      end
      check("wrap_pops",  32'(n_pop),  32'd12);
      check("wrap_pushes", 32'(n_push), 32'd12);
      drive_push(1'b0, 32'd0);
      StallD_i = 1'b0;

      // 5: asynchronous reset between edges
      drive_push(1'b1, 32'h200);
      tick();
      StallD_i = 1'b1;
      for (int k = 1; k < 4; k++) begin
         drive_push(1'b1, 32'h200 + 32'(4 * k));
         tick();
      end
      drive_push(1'b0, 32'd0);
      check("mid_pre_count", 32'(count_o), 32'd3);
      check("mid_pre_valid", 32'(ValidD_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_bubble("mid_rst");
      check("mid_rst_count", 32'(count_o), 32'd0);
      check("mid_rst_ready", 32'(push_ready_o), 32'd1);
      #1;
      rst_n    = 1'b1;
      StallD_i = 1'b0;

      // 6: empty idle
      for (int k = 0; k < 3; k++) begin
         tick();
         check("idle_valid", 32'(ValidD_o), 32'd0);
         check("idle_instr", InstrD_o, NOP);
         check("idle_ready", 32'(push_ready_o), 32'd1);
         check("idle_count", 32'(count_o), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
